// File: rtl/sub_64bit_seq_if.sv
// Operand/result handshake bundle for sub_64bit_seq.
// The ovf signal exists only when SUB64_OVF_EN is defined.
interface sub_64bit_seq_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic              bin;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dout;
    logic              bout;
    logic              out_valid;
    logic              out_ready;
`ifdef SUB64_OVF_EN
    logic              ovf;

    modport master (
        output din1, din2, bin, in_valid, out_ready,
        input  in_ready, dout, bout, out_valid, ovf
    );
    modport slave (
        input  din1, din2, bin, in_valid, out_ready,
        output in_ready, dout, bout, out_valid, ovf
    );
`else
    modport master (
        output din1, din2, bin, in_valid, out_ready,
        input  in_ready, dout, bout, out_valid
    );
    modport slave (
        input  din1, din2, bin, in_valid, out_ready,
        output in_ready, dout, bout, out_valid
    );
`endif
endinterface

// File: rtl/sub_64bit_seq.sv
// Multi-cycle subtractor: dout = din1 - din2 - bin, CHUNK_W bits per cycle with a rippled borrow.
// Define SUB64_OVF_EN to add the signed-overflow output ovf.
module sub_64bit_seq #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    sub_64bit_seq_if.slave  bus
);
    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned MSB    = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
`ifdef SUB64_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W:0]   diff;
    logic               last;

    // Current chunk slice and its (CHUNK_W+1)-bit difference; the top bit is the borrow.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
                b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
            end
        end
        diff = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_W{1'b0}}, borrow_q};
        last = (cnt_q == CNT_W'(NCHUNK - 1));
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SUB64_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.din1;
                    b_d        = bus.din2;
                    borrow_d   = bus.bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        dout_d[i*CHUNK_W +: CHUNK_W] = diff[CHUNK_W-1:0];
                    end
                end
                borrow_d = diff[CHUNK_W];
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    bout_d      = diff[CHUNK_W];
`ifdef SUB64_OVF_EN
                    // Top chunk's MSB is the final result MSB, so ovf includes bin.
                    ovf_d       = (a_q[MSB] != b_q[MSB]) & (diff[CHUNK_W-1] != a_q[MSB]);
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB64_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB64_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.bout      = bout_q;
`ifdef SUB64_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_64bit_seq.sv
// Randomized self-checking bench for sub_64bit_seq against an arithmetic reference model.
// Works with and without SUB64_OVF_EN.
module tb_sub_64bit_seq;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CHUNK_W = 16;
    localparam int unsigned NCHUNK  = DATA_W / CHUNK_W;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sub_64bit_seq_if #(.DATA_W(DATA_W)) bus ();

    sub_64bit_seq #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: plain integer subtraction, borrow as an unsigned compare, overflow as signed range.
    task automatic ref_sub(input logic [63:0] a, input logic [63:0] b, input logic bi,
                           output logic [63:0] d, output logic bo, output logic ov);
        logic signed [65:0] s;
        d  = a - b - 64'(bi);
        bo = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
        s  = 66'($signed(a)) - 66'($signed(b)) - 66'(bi);
        ov = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                          input int hold, input bit pulse);
        logic [63:0] ed;
        logic        eb;
        logic        eo;
        int          cyc;
        ref_sub(a, b, bi, ed, eb, eo);
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.in_ready) check_val("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.din1 = a; bus.din2 = b; bus.bin = bi; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.din1 = rnd64(); bus.din2 = rnd64(); bus.bin = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        check_val("in_ready_busy", 64'(bus.in_ready), 64'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("latency", 64'(cyc), 64'(NCHUNK));
        check_val("dout", bus.dout, ed);
        check_val("bout", 64'(bus.bout), 64'(eb));
`ifdef SUB64_OVF_EN
        check_val("ovf", 64'(bus.ovf), 64'(eo));
`endif
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.din1 = rnd64(); bus.din2 = rnd64();
            end
            @(posedge clk); #1;
            check_val("hold_valid", 64'(bus.out_valid), 64'd1);
            check_val("hold_dout", bus.dout, ed);
            check_val("hold_bout", 64'(bus.bout), 64'(eb));
            check_val("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("handoff_valid", 64'(bus.out_valid), 64'd0);
        check_val("handoff_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        rst = 1'b1;
        bus.din1 = '0; bus.din2 = '0; bus.bin = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_dout", bus.dout, 64'd0);
        check_val("rst_bout", 64'(bus.bout), 64'd0);
`ifdef SUB64_OVF_EN
        check_val("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(64'h10, 64'h01, 1'b0, 0, 1'b0);
        run_op(64'h0, 64'h1, 1'b0, 0, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, 1'b0);
        run_op(64'h0001_0000, 64'h0000_FFFF, 1'b1, 0, 1'b0);
        run_op(64'h0, 64'h0, 1'b1, 0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10, 1'b1);

        // Abandon an operation mid-BUSY with reset
        bus.din1 = 64'hDEAD_BEEF_0000_0001; bus.din2 = 64'h1; bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check_val("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("midrst_dout", bus.dout, 64'd0);
        check_val("midrst_bout", 64'(bus.bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 0, 1'b0);

        // Randomized operations with varied operand relationships
        for (int n = 0; n < 40; n++) begin
            a = rnd64();
            case ($urandom_range(0, 3))
                0: b = rnd64();
                1: b = a;
                2: b = a + 64'($urandom_range(0, 3));
                default: b = {a[63] ^ 1'b1, a[62:0]} ^ 64'($urandom());
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
